// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master SRAM port arbiter: response tags, owner ids, widths.
package mem_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_read;
  } resp_tag_t;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Response tag delay line matching the SRAM read latency, plus rvalid/rdata steering to
// the master that owned the grant.
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_valid_i,
  input  logic                  push_owner_i,
  input  logic                  push_is_read_i,
  input  logic [DATA_WIDTH-1:0] sram_dout_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o
);

  resp_tag_t tag_q [RD_LATENCY];
  resp_tag_t tag_d [RD_LATENCY];
  resp_tag_t tag_out;

  always_comb begin
    tag_d[0].valid   = push_valid_i;
    tag_d[0].owner   = owner_e'(push_owner_i);
    tag_d[0].is_read = push_is_read_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Reset drops in-flight tags so no response escapes for pre-reset grants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    tag_out     = tag_q[RD_LATENCY-1];
    m0_rvalid_o = tag_out.valid && (tag_out.owner == OWN_M0);
    m1_rvalid_o = tag_out.valid && (tag_out.owner == OWN_M1);
    m0_rdata_o  = (m0_rvalid_o && tag_out.is_read) ? sram_dout_i : '0;
    m1_rdata_o  = (m1_rvalid_o && tag_out.is_read) ? sram_dout_i : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between core (m0) and UART loader (m1) onto one single-port SRAM.
// Optional MEM_ARB_STATS_EN adds a saturating conflict-cycle counter output.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [BE_WIDTH-1:0]   sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt_o
`endif
);

  owner_e last_grant_q, last_grant_d;
  logic   gnt0, gnt1, granted, sel_we;

  // Grant is combinational; it is held off while reset is asserted.
  always_comb begin
    gnt0         = ~rst_i & m0_req_i & (~m1_req_i | (last_grant_q == OWN_M1));
    gnt1         = ~rst_i & m1_req_i & ~gnt0;
    granted      = gnt0 | gnt1;
    sel_we       = gnt1 ? m1_we_i : m0_we_i;
    last_grant_d = last_grant_q;
    if (gnt0) last_grant_d = OWN_M0;
    if (gnt1) last_grant_d = OWN_M1;

    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (granted) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = ~sel_we;
      sram_wmask_o = gnt1 ? m1_be_i    : m0_be_i;
      sram_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
      sram_din_o   = gnt1 ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_grant_q <= OWN_M1;
    else       last_grant_q <= last_grant_d;
  end

  mem_arb_resp_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_resp_pipe (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_valid_i   (granted),
    .push_owner_i   (gnt1),
    .push_is_read_i (~sel_we),
    .sram_dout_i    (sram_dout_i),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o)
  );

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (m0_req_i && m1_req_i && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LATENCY 1 and 2) share stimulus and are
// checked every cycle against a transaction-level model of arbitration and SRAM contents.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wd, m1_wd;

  logic        gnt0_1, gnt1_1, rv0_1, rv1_1, csb_1, web_1;
  logic [31:0] rd0_1, rd1_1, din_1, dout_1;
  logic [3:0]  wm_1;
  logic [11:0] addr_1;
  logic        gnt0_2, gnt1_2, rv0_2, rv1_2, csb_2, web_2;
  logic [31:0] rd0_2, rd1_2, din_2, dout_2;
  logic [3:0]  wm_2;
  logic [11:0] addr_2;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt_1, cnt_2;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(12), .RD_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(gnt0_1), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wd), .m0_rvalid_o(rv0_1), .m0_rdata_o(rd0_1),
    .m1_req_i(m1_req), .m1_gnt_o(gnt1_1), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wd), .m1_rvalid_o(rv1_1), .m1_rdata_o(rd1_1),
    .sram_csb_o(csb_1), .sram_web_o(web_1), .sram_wmask_o(wm_1), .sram_addr_o(addr_1),
    .sram_din_o(din_1), .sram_dout_i(dout_1)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt_o(cnt_1)
`endif
  );

  mem_port_arbiter #(.ADDR_WIDTH(12), .RD_LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(gnt0_2), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wd), .m0_rvalid_o(rv0_2), .m0_rdata_o(rd0_2),
    .m1_req_i(m1_req), .m1_gnt_o(gnt1_2), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wd), .m1_rvalid_o(rv1_2), .m1_rdata_o(rd1_2),
    .sram_csb_o(csb_2), .sram_web_o(web_2), .sram_wmask_o(wm_2), .sram_addr_o(addr_2),
    .sram_din_o(din_2), .sram_dout_i(dout_2)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt_o(cnt_2)
`endif
  );

  // SRAM macro models: latency-1 registered read, latency-2 adds one output stage.
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:4095];
  logic [31:0] dout2_a;

  always @(posedge clk) begin
    if (!csb_1) begin
      if (!web_1) begin
        for (int b = 0; b < 4; b++) if (wm_1[b]) mem1[addr_1][b*8 +: 8] <= din_1[b*8 +: 8];
        dout_1 <= 32'hBAD0BAD0;
      end else begin
        dout_1 <= mem1[addr_1];
      end
    end
  end

  always @(posedge clk) begin
    if (!csb_2) begin
      if (!web_2) begin
        for (int b = 0; b < 4; b++) if (wm_2[b]) mem2[addr_2][b*8 +: 8] <= din_2[b*8 +: 8];
        dout2_a <= 32'hBAD0BAD0;
      end else begin
        dout2_a <= mem2[addr_2];
      end
    end
    dout_2 <= dout2_a;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: expected responses keyed by grant cycle, plus memory image.
  typedef struct {
    int          gcyc;
    bit          owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] model_mem [0:4095];
  bit          last_m1 = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check_resp(input int lat, input logic rv0, input logic [31:0] rd0,
                            input logic rv1, input logic [31:0] rd1);
    logic        ev0 = 1'b0;
    logic        ev1 = 1'b0;
    logic [31:0] ed  = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].gcyc + lat == cyc) begin
        if (exp_q[i].owner) ev1 = 1'b1;
        else                ev0 = 1'b1;
        ed = exp_q[i].data;
      end
    end
    chk($sformatf("L%0d_m0_resp", lat), {31'b0, rv0, rd0}, {31'b0, ev0, ev0 ? ed : 32'h0});
    chk($sformatf("L%0d_m1_resp", lat), {31'b0, rv1, rd1}, {31'b0, ev1, ev1 ? ed : 32'h0});
  endtask

  always @(negedge clk) begin
    logic        eg0, eg1;
    logic [51:0] exp_bus;
    if (rst) begin
      exp_q.delete();
      last_m1 = 1'b1;
      exp_bus = {4'b0011, 4'h0, 12'h0, 32'h0};
      chk("rst_bus_L1", {12'b0, gnt0_1, gnt1_1, csb_1, web_1, wm_1, addr_1, din_1}, {12'b0, exp_bus});
      chk("rst_bus_L2", {12'b0, gnt0_2, gnt1_2, csb_2, web_2, wm_2, addr_2, din_2}, {12'b0, exp_bus});
      chk("rst_resp", {rv0_1, rv1_1, rv0_2, rv1_2, rd0_1 | rd1_1 | rd0_2 | rd1_2}, '0);
    end else begin
      check_resp(1, rv0_1, rd0_1, rv1_1, rd1_1);
      check_resp(2, rv0_2, rd0_2, rv1_2, rd1_2);
      while (exp_q.size() > 0 && exp_q[0].gcyc + 2 <= cyc) void'(exp_q.pop_front());

      eg0 = m0_req && (!m1_req || last_m1);
      eg1 = m1_req && !eg0;
      if (eg0)
        exp_bus = {2'b10, 1'b0, ~m0_we, m0_be, m0_addr, m0_wd};
      else if (eg1)
        exp_bus = {2'b01, 1'b0, ~m1_we, m1_be, m1_addr, m1_wd};
      else
        exp_bus = {4'b0011, 4'h0, 12'h0, 32'h0};
      chk("arb_bus_L1", {12'b0, gnt0_1, gnt1_1, csb_1, web_1, wm_1, addr_1, din_1}, {12'b0, exp_bus});
      chk("arb_bus_L2", {12'b0, gnt0_2, gnt1_2, csb_2, web_2, wm_2, addr_2, din_2}, {12'b0, exp_bus});

      if (eg0 || eg1) begin
        logic        we;
        logic [11:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        rsp_t        r;
        we = eg1 ? m1_we : m0_we;
        a  = eg1 ? m1_addr : m0_addr;
        be = eg1 ? m1_be : m0_be;
        wd = eg1 ? m1_wd : m0_wd;
        r.gcyc  = cyc;
        r.owner = eg1;
        r.data  = we ? 32'h0 : model_mem[a];
        exp_q.push_back(r);
        if (we) for (int b = 0; b < 4; b++) if (be[b]) model_mem[a][b*8 +: 8] = wd[b*8 +: 8];
        last_m1 = eg1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m0(input logic r, input logic [11:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
    m0_req = r; m0_addr = a; m0_we = w; m0_be = b; m0_wd = d;
  endtask

  task automatic set_m1(input logic r, input logic [11:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
    m1_req = r; m1_addr = a; m1_we = w; m1_be = b; m1_wd = d;
  endtask

  task automatic idle();
    set_m0(0, 12'h0, 0, 4'h0, 32'h0);
    set_m1(0, 12'h0, 0, 4'h0, 32'h0);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached before end of test");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rnd_addr [4];
    rnd_addr[0] = 12'h001; rnd_addr[1] = 12'h002; rnd_addr[2] = 12'h010; rnd_addr[3] = 12'h020;

    rst = 1'b1;
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("reset_csb_web", {60'b0, csb_1, web_1, csb_2, web_2}, 64'hF);
    chk("reset_gnt_rvalid", {56'b0, gnt0_1, gnt1_1, rv0_1, rv1_1, gnt0_2, gnt1_2, rv0_2, rv1_2}, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single m1 write, then read back.
    set_m1(1, 12'h010, 1, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("m1_wr_gnt_csb_web", {60'b0, gnt1_1, gnt0_1, csb_1, web_1}, 64'b1000);
    tick();
    idle();
    @(negedge clk);
    chk("m1_wr_rvalid_rdata", {31'b0, rv1_1, rd1_1}, {31'b0, 1'b1, 32'h0});
    tick();
    set_m1(1, 12'h010, 0, 4'h0, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("m1_rd_data", {31'b0, rv1_1, rd1_1}, {31'b0, 1'b1, 32'hDEADBEEF});
    tick();

    // Seed tie addresses, then four cycles of dual requests.
    set_m0(1, 12'h001, 1, 4'hF, 32'h000000A1);
    tick();
    idle();
    set_m1(1, 12'h002, 1, 4'hF, 32'h000000B2);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_m0(1, 12'h001, 0, 4'h0, 32'h0);
      set_m1(1, 12'h002, 0, 4'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("tie_gnt%0d", i), {62'b0, gnt0_1, gnt1_1}, (i % 2 == 0) ? 64'b10 : 64'b01);
      if (i > 0)
        chk($sformatf("tie_rsp%0d", i), {30'b0, rv0_1, rv1_1, rd0_1 | rd1_1},
            (i % 2 == 1) ? {30'b0, 2'b10, 32'h000000A1} : {30'b0, 2'b01, 32'h000000B2});
      tick();
    end
    idle();
    repeat (3) tick();

    // Byte-masked write over all-ones.
    set_m0(1, 12'h020, 1, 4'hF, 32'hFFFFFFFF);
    tick();
    set_m0(1, 12'h020, 1, 4'b0101, 32'h11223344);
    tick();
    set_m0(1, 12'h020, 0, 4'h0, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("byte_mask_readback", {31'b0, rv0_1, rd0_1}, {31'b0, 1'b1, 32'hFF22FF44});
    repeat (3) tick();

    // Back-to-back mixed traffic over previously written addresses.
    for (int i = 0; i < 24; i++) begin
      set_m0(1'($urandom_range(0, 1)), rnd_addr[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom);
      set_m1(1'($urandom_range(0, 1)), rnd_addr[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom);
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset one cycle after an m0 read grant: the response must never appear.
    set_m0(1, 12'h020, 0, 4'h0, 32'h0);
    tick();
    rst = 1'b1;
    idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_rvalid%0d", i), {60'b0, rv0_2, rv1_2, rv0_1, rv1_1}, 64'h0);
      tick();
      if (i == 1) rst = 1'b0;
    end

`ifdef MEM_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_m0(1, 12'h001, 0, 4'h0, 32'h0);
      set_m1(1, 12'h002, 0, 4'h0, 32'h0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("conflict_cnt_5", {48'b0, cnt_1}, 64'd5);
    force u_dut1.conflict_cnt_q = 16'hFFFE;
    #1;
    release u_dut1.conflict_cnt_q;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_m0(1, 12'h001, 0, 4'h0, 32'h0);
      set_m1(1, 12'h002, 0, 4'h0, 32'h0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("conflict_cnt_sat", {48'b0, cnt_1}, 64'hFFFF);
    chk("conflict_cnt_L2", {48'b0, cnt_2}, 64'd8);
    repeat (3) tick();
`endif

    summary();
    $finish;
  end

endmodule
